// File: rtl/elevator_motion_pkg.sv
// Shared definitions for the elevator cab motion block and the goal selector.
// Contents: floor label encodings, the motion FSM state type, default timing
// constants and small helpers for label arithmetic and per-floor clear decode.
package elevator_motion_pkg;

    // Floor labels are ordered, so unsigned compares give above/below.
    localparam logic [1:0] labelF1 = 2'b00;
    localparam logic [1:0] labelF2 = 2'b01;
    localparam logic [1:0] labelF3 = 2'b10;

    localparam int unsigned TRAVEL_CYCLES_DEF = 4;
    localparam int unsigned DOOR_CYCLES_DEF   = 3;

    typedef enum logic [1:0] {
        IDLE,
        MOVE,
        DOOR
    } state_e;

    // Step one floor along the label chain, saturating at the end floors.
    // Unknown labels hold so a corrupted floor never walks off the chain.
    function automatic logic [1:0] step_floor(input logic [1:0] cur, input logic up);
        logic [1:0] nxt;
        nxt = cur;
        if (up) begin
            if (cur == labelF1)      nxt = labelF2;
            else if (cur == labelF2) nxt = labelF3;
        end else begin
            if (cur == labelF3)      nxt = labelF2;
            else if (cur == labelF2) nxt = labelF1;
        end
        return nxt;
    endfunction

    // One-hot {clr3, clr2, clr1} for a floor label; zero for invalid labels.
    function automatic logic [2:0] clr_for(input logic [1:0] lbl);
        logic [2:0] c;
        c = 3'b000;
        if (lbl == labelF1)      c = 3'b001;
        else if (lbl == labelF2) c = 3'b010;
        else if (lbl == labelF3) c = 3'b100;
        return c;
    endfunction

endpackage

// File: rtl/elevator_motion_dwell_timer.sv
// dwell_timer: loadable down-counter used for both travel and door dwell.
// Ports:
//   clk      - system clock, rising edge
//   rst      - synchronous active-high reset, clears the count
//   load     - load load_val this cycle (takes priority over counting)
//   load_val - value to load
//   done     - count has reached zero
// The count saturates at zero until reloaded.
module dwell_timer #(
    parameter int unsigned Width = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [Width-1:0] load_val,
    output logic             done
);

    logic [Width-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/elevator_motion.sv
// elevator_motion: moves the cab one floor at a time toward the goal floor
// supplied by the selector, opens the door on arrival and pulses a per-floor
// clear so the request latch drops the serviced call.
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   gf                - goal floor label from the selector
//   led1..led3        - pending request per floor
//   floor             - current cab floor label
//   move_handler      - busy (MOVE or DOOR); selector freezes gf while high
//   dir_up            - travelling up (MOVE only)
//   door_open         - door open (DOOR)
//   clr1..clr3        - one-cycle request clear on arrival
// All outputs are registered.
module elevator_motion
    import elevator_motion_pkg::*;
#(
    parameter int unsigned TRAVEL_CYCLES = TRAVEL_CYCLES_DEF,
    parameter int unsigned DOOR_CYCLES   = DOOR_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] gf,
    input  logic       led1,
    input  logic       led2,
    input  logic       led3,
    output logic [1:0] floor,
    output logic       move_handler,
    output logic       dir_up,
    output logic       door_open,
    output logic       clr1,
    output logic       clr2,
    output logic       clr3
);

    localparam int unsigned MaxCycles  = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES
                                                                     : DOOR_CYCLES;
    localparam int unsigned CntW       = $clog2(MaxCycles) + 1;
    localparam logic [CntW-1:0] TravelLoad = CntW'(TRAVEL_CYCLES - 1);
    localparam logic [CntW-1:0] DoorLoad   = CntW'(DOOR_CYCLES - 1);

    state_e     state_q, state_d;
    logic [1:0] floor_q, floor_d;
    logic [1:0] target_q, target_d;
    logic       mh_q, mh_d;
    logic       dir_q, dir_d;
    logic       door_q, door_d;
    logic [2:0] clr_q, clr_d;
    // Set when DOOR returns to IDLE; burns one IDLE cycle so the selector
    // can recompute gf before it is trusted again.
    logic       holdoff_q, holdoff_d;

    logic            tmr_load;
    logic [CntW-1:0] tmr_val;
    logic            tmr_done;

    logic       led_sel;
    logic       gf_valid;
    logic [1:0] next_floor;

    dwell_timer #(
        .Width (CntW)
    ) u_dwell_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // gf is only trusted when it names a real floor with a pending request.
    always_comb begin
        led_sel = 1'b0;
        if (gf == labelF1)      led_sel = led1;
        else if (gf == labelF2) led_sel = led2;
        else if (gf == labelF3) led_sel = led3;
    end

    assign gf_valid   = led_sel;
    assign next_floor = step_floor(floor_q, dir_q);

    always_comb begin
        state_d   = state_q;
        floor_d   = floor_q;
        target_d  = target_q;
        mh_d      = mh_q;
        dir_d     = dir_q;
        door_d    = door_q;
        clr_d     = 3'b000;
        holdoff_d = holdoff_q;
        tmr_load  = 1'b0;
        tmr_val   = '0;

        unique case (state_q)
            IDLE: begin
                if (holdoff_q) begin
                    holdoff_d = 1'b0;
                end else if (gf_valid) begin
                    mh_d     = 1'b1;
                    tmr_load = 1'b1;
                    if (gf == floor_q) begin
                        state_d = DOOR;
                        door_d  = 1'b1;
                        dir_d   = 1'b0;
                        clr_d   = clr_for(gf);
                        tmr_val = DoorLoad;
                    end else begin
                        state_d  = MOVE;
                        target_d = gf;
                        dir_d    = (gf > floor_q);
                        tmr_val  = TravelLoad;
                    end
                end
            end
            MOVE: begin
                if (tmr_done) begin
                    floor_d  = next_floor;
                    tmr_load = 1'b1;
                    if (next_floor == target_q) begin
                        state_d = DOOR;
                        door_d  = 1'b1;
                        dir_d   = 1'b0;
                        clr_d   = clr_for(target_q);
                        tmr_val = DoorLoad;
                    end else begin
                        tmr_val = TravelLoad;
                    end
                end
            end
            DOOR: begin
                if (tmr_done) begin
                    state_d   = IDLE;
                    door_d    = 1'b0;
                    mh_d      = 1'b0;
                    holdoff_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            floor_q   <= labelF1;
            target_q  <= labelF1;
            mh_q      <= 1'b0;
            dir_q     <= 1'b0;
            door_q    <= 1'b0;
            clr_q     <= 3'b000;
            holdoff_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            target_q  <= target_d;
            mh_q      <= mh_d;
            dir_q     <= dir_d;
            door_q    <= door_d;
            clr_q     <= clr_d;
            holdoff_q <= holdoff_d;
        end
    end

    assign floor        = floor_q;
    assign move_handler = mh_q;
    assign dir_up       = dir_q;
    assign door_open    = door_q;
    assign clr1         = clr_q[0];
    assign clr2         = clr_q[1];
    assign clr3         = clr_q[2];

endmodule
